// File: rtl/controlador_pisos_if.sv
// Signal bundle between the elevator floor controller and its environment:
// floor calls in, car position / motion / door status out.
interface controlador_pisos_if;
    logic [3:0] llamada;
    logic [1:0] piso;
    logic [1:0] last_piso;
    logic [1:0] direccion;
    logic       puerta_abierta;
    logic [3:0] pendientes;
    logic       llegada;

    // Environment side: issues calls, observes the car.
    modport master (
        output llamada,
        input  piso, last_piso, direccion, puerta_abierta, pendientes, llegada
    );

    // Controller side.
    modport slave (
        input  llamada,
        output piso, last_piso, direccion, puerta_abierta, pendientes, llegada
    );
endinterface

// File: rtl/controlador_pisos.sv
// Four-floor elevator controller (floor codes 00=-1, 01=1, 10=2, 11=3).
// Latches floor calls, travels one floor per T_VIAJE cycles toward outstanding
// calls, holds the door open for T_PUERTA cycles at each served floor, and
// prefers to keep going in the last travel direction before reversing.
module controlador_pisos #(
    parameter int T_VIAJE  = 50000000,
    parameter int T_PUERTA = 100000000
) (
    input  logic                 clk_nuevo,
    input  logic                 reset,
    controlador_pisos_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, MOVIENDO, PUERTA} estado_t;
    typedef enum logic [1:0] {DIR_PARADO = 2'b00, DIR_SUBE = 2'b01, DIR_BAJA = 2'b10} dir_t;

    localparam logic [26:0] VIAJE_MAX  = 27'(T_VIAJE - 1);
    localparam logic [26:0] PUERTA_MAX = 27'(T_PUERTA - 1);

    estado_t     estado_q, estado_d;
    dir_t        direccion_q, direccion_d;
    logic        dir_prev_q, dir_prev_d;      // 1 = last travel was upward
    logic [26:0] cnt_q, cnt_d;
    logic [1:0]  piso_q, piso_d;
    logic [1:0]  last_piso_q, last_piso_d;
    logic        puerta_q, puerta_d;
    logic [3:0]  pend_q, pend_d;
    logic        llegada_q, llegada_d;

    logic [3:0]  calls;
    logic        hay_arriba, hay_abajo;
    logic [1:0]  piso_sig;
    dir_t        dir_elegida;

    // Direction choice: keep the previous travel side if it has work, else turn.
    function automatic dir_t elegir(input logic pref_sube, input logic arriba, input logic abajo);
        if (pref_sube)
            return arriba ? DIR_SUBE : (abajo ? DIR_BAJA : DIR_PARADO);
        else
            return abajo ? DIR_BAJA : (arriba ? DIR_SUBE : DIR_PARADO);
    endfunction

    // Next-state and output computation for the control FSM.
    always_comb begin
        estado_d    = estado_q;
        direccion_d = direccion_q;
        dir_prev_d  = dir_prev_q;
        cnt_d       = cnt_q;
        piso_d      = piso_q;
        last_piso_d = last_piso_q;
        puerta_d    = puerta_q;
        llegada_d   = 1'b0;

        // Calls seen this edge count as outstanding immediately.
        calls       = pend_q | bus.llamada;
        pend_d      = calls;
        // Floor codes are ordered, so above/below are plain bit masks.
        hay_arriba  = |(calls & (4'b1110 << piso_q));
        hay_abajo   = |(calls & ~(4'b1111 << piso_q));
        dir_elegida = elegir(dir_prev_q, hay_arriba, hay_abajo);
        piso_sig    = (direccion_q == DIR_SUBE) ? piso_q + 2'd1 : piso_q - 2'd1;

        case (estado_q)
            IDLE: begin
                direccion_d = DIR_PARADO;
                if (calls[piso_q]) begin
                    pend_d[piso_q] = 1'b0;
                    estado_d       = PUERTA;
                    cnt_d          = '0;
                    puerta_d       = 1'b1;
                    llegada_d      = 1'b1;
                end else if (|calls) begin
                    estado_d    = MOVIENDO;
                    cnt_d       = '0;
                    direccion_d = dir_elegida;
                end
            end
            MOVIENDO: begin
                if (cnt_q == VIAJE_MAX) begin
                    cnt_d       = '0;
                    last_piso_d = piso_q;
                    piso_d      = piso_sig;
                    if (calls[piso_sig]) begin
                        pend_d[piso_sig] = 1'b0;
                        estado_d         = PUERTA;
                        puerta_d         = 1'b1;
                        llegada_d        = 1'b1;
                        dir_prev_d       = (direccion_q == DIR_SUBE);
                        direccion_d      = DIR_PARADO;
                    end
                end else begin
                    cnt_d = cnt_q + 27'd1;
                end
            end
            PUERTA: begin
                // A call for the floor the door is open at is absorbed.
                pend_d[piso_q] = 1'b0;
                if (bus.llamada[piso_q]) begin
                    cnt_d = '0;
                end else if (cnt_q == PUERTA_MAX) begin
                    cnt_d       = '0;
                    puerta_d    = 1'b0;
                    direccion_d = dir_elegida;
                    estado_d    = (dir_elegida == DIR_PARADO) ? IDLE : MOVIENDO;
                end else begin
                    cnt_d = cnt_q + 27'd1;
                end
            end
            default: begin
                estado_d    = IDLE;
                direccion_d = DIR_PARADO;
                puerta_d    = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset discards all calls and counts.
    always_ff @(posedge clk_nuevo or posedge reset) begin
        if (reset) begin
            estado_q    <= IDLE;
            direccion_q <= DIR_PARADO;
            dir_prev_q  <= 1'b1;
            cnt_q       <= '0;
            piso_q      <= 2'b01;
            last_piso_q <= 2'b01;
            puerta_q    <= 1'b0;
            pend_q      <= '0;
            llegada_q   <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            direccion_q <= direccion_d;
            dir_prev_q  <= dir_prev_d;
            cnt_q       <= cnt_d;
            piso_q      <= piso_d;
            last_piso_q <= last_piso_d;
            puerta_q    <= puerta_d;
            pend_q      <= pend_d;
            llegada_q   <= llegada_d;
        end
    end

    assign bus.piso           = piso_q;
    assign bus.last_piso      = last_piso_q;
    assign bus.direccion      = direccion_q;
    assign bus.puerta_abierta = puerta_q;
    assign bus.pendientes     = pend_q;
    assign bus.llegada        = llegada_q;

endmodule
